// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: tracks EX/MEM/WB
// destination metadata and derives stall, flush, bubble and forwarding controls.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Operand source select: MEM result beats WB result; register 0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic             src_en,
        input logic [REG_W-1:0] src,
        input logic             m_v,
        input logic             m_we,
        input logic [REG_W-1:0] m_rd,
        input logic             w_v,
        input logic             w_we,
        input logic [REG_W-1:0] w_rd
    );
        logic [1:0] sel;
        if (!src_en) begin
            sel = 2'b00;
        end else if (m_v && m_we && (m_rd != REG_ZERO) && (m_rd == src)) begin
            sel = 2'b01;
        end else if (w_v && w_we && (w_rd != REG_ZERO) && (w_rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (&cnt) begin
            nxt = cnt;
        end else begin
            nxt = cnt + CNT_ONE;
        end
        return nxt;
    endfunction

    logic             ex_v_q, ex_v_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic             ex_use_rs_q, ex_use_rs_d;
    logic             ex_use_rt_q, ex_use_rt_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_we_q, ex_we_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_v_q, mem_v_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_load_q, mem_load_d;
    logic             wb_v_q, wb_v_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic             wb_load_q, wb_load_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             lu_hit_s;
    logic             pc_en_s;
    logic             ifid_en_s;
    logic             ifid_flush_s;
    logic             idex_bubble_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;
    logic             unused_load_s;

    // The load flag is carried through MEM/WB for completeness but not consumed here.
    assign unused_load_s = mem_load_q ^ wb_load_q;

    // Load-use detection against the instruction currently in EX.
    always_comb begin
        lu_hit_s = 1'b0;
        if (ex_v_q && ex_load_q && ex_we_q && (ex_rd_q != REG_ZERO) && id_valid) begin
            lu_hit_s = (id_use_rs && (id_rs == ex_rd_q)) ||
                       (id_use_rt && (id_rt == ex_rd_q));
        end else begin
            lu_hit_s = 1'b0;
        end
    end

    // Prioritised pipeline control: reset, freeze, branch, load-use, normal.
    always_comb begin
        pc_en_s       = 1'b1;
        ifid_en_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        if (rst) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (ext_stall) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so a concurrent load-use is moot.
            pc_en_s       = 1'b1;
            ifid_en_s     = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (lu_hit_s) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            pc_en_s       = 1'b1;
            ifid_en_s     = 1'b1;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
        end
    end

    // Forwarding selects follow the held shadows, including while frozen.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (rst) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(ex_v_q && ex_use_rs_q, ex_rs_q,
                              mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
            fwd_b_s = fwd_sel(ex_v_q && ex_use_rt_q, ex_rt_q,
                              mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
        end
    end

    // Next shadow and counter state: advance one stage unless frozen.
    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        ex_use_rs_d = ex_use_rs_q;
        ex_use_rt_d = ex_use_rt_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_load_d   = ex_load_q;
        mem_v_d     = mem_v_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        mem_load_d  = mem_load_q;
        wb_v_d      = wb_v_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        wb_load_d   = wb_load_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ext_stall) begin
            wb_v_d      = mem_v_q;
            wb_rd_d     = mem_rd_q;
            wb_we_d     = mem_we_q;
            wb_load_d   = mem_load_q;
            mem_v_d     = ex_v_q;
            mem_rd_d    = ex_rd_q;
            mem_we_d    = ex_we_q;
            mem_load_d  = ex_load_q;
            ex_v_d      = id_valid && !idex_bubble_s;
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
            ex_use_rs_d = id_use_rs;
            ex_use_rt_d = id_use_rt;
            ex_rd_d     = id_rd;
            ex_we_d     = id_we;
            ex_load_d   = id_load;
            if (ex_branch_taken) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
                stall_cnt_d = stall_cnt_q;
            end else if (lu_hit_s) begin
                flush_cnt_d = flush_cnt_q;
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with synchronous reset that drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q      <= 1'b0;
            ex_rs_q     <= REG_ZERO;
            ex_rt_q     <= REG_ZERO;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
            ex_rd_q     <= REG_ZERO;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= REG_ZERO;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= REG_ZERO;
            wb_we_q     <= 1'b0;
            wb_load_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_use_rs_q <= ex_use_rs_d;
            ex_use_rt_q <= ex_use_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_load_q  <= mem_load_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_load_q   <= wb_load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en       = pc_en_s;
    assign ifid_en     = ifid_en_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control, forwarding and
// counter values for ALU chains, load-use, branches, freeze, reset and saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        ext_stall;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_load;
    logic        ex_branch_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks_cnt;
    int errors_cnt;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ext_stall       (ext_stall),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_rd           (id_rd),
        .id_we           (id_we),
        .id_load         (id_load),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic id_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic we, input logic ld);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_rd     = rd;
        id_we     = we;
        id_load   = ld;
    endtask

    task automatic nop_in();
        id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop_in();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic chk_ctrl(input string tag, input logic pc, input logic ifid,
                            input logic flush, input logic bubble);
        chk({tag, "_pc_en"}, {31'd0, pc_en}, {31'd0, pc});
        chk({tag, "_ifid_en"}, {31'd0, ifid_en}, {31'd0, ifid});
        chk({tag, "_ifid_flush"}, {31'd0, ifid_flush}, {31'd0, flush});
        chk({tag, "_idex_bubble"}, {31'd0, idex_bubble}, {31'd0, bubble});
    endtask

    initial begin
        checks_cnt      = 0;
        errors_cnt      = 0;
        rst             = 1'b1;
        ext_stall       = 1'b0;
        ex_branch_taken = 1'b0;
        nop_in();
        settle();
        chk_ctrl("rst_ctrl", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        tick();
        tick();
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        rst = 1'b0;
        settle();
        chk_ctrl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_fwd_b", {30'd0, fwd_b}, 32'd0);

        // back-to-back ALU: add t0 ; sub t2,t1,t0
        id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        id_in(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        settle();
        chk_ctrl("alu_id", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        nop_in();
        settle();
        chk("alu_fwd_b", {30'd0, fwd_b}, 32'd1);
        chk("alu_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("alu_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        drain();

        // load-use: lw t0 ; sub t2,t1,t0
        id_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        id_in(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        settle();
        chk_ctrl("lu_hit", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        chk_ctrl("lu_clear", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        tick();
        nop_in();
        settle();
        chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
        chk("lu_fwd_a", {30'd0, fwd_a}, 32'd0);
        drain();

        // register 0: lw $0 followed by a use of $0 never stalls or forwards
        id_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        id_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        settle();
        chk_ctrl("r0_no_stall", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        nop_in();
        settle();
        chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("r0_fwd_b", {30'd0, fwd_b}, 32'd0);
        chk("r0_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        drain();

        // MEM beats WB: two writers of $9, consumer reads rs=9 (rt=9 unused)
        id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        id_in(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        nop_in();
        settle();
        chk("prio_fwd_a", {30'd0, fwd_a}, 32'd1);
        chk("prio_fwd_b_unused", {30'd0, fwd_b}, 32'd0);
        drain();

        // branch taken in the same cycle as a load-use hit
        id_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        id_in(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        settle();
        chk_ctrl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        ex_branch_taken = 1'b0;
        settle();
        chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("br_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        chk_ctrl("br_after", 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // ext_stall held 3 cycles with a pending load-use and an active forward
        id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        id_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        id_in(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        ext_stall = 1'b1;
        settle();
        chk_ctrl("xs_ctrl", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("xs_fwd_a0", {30'd0, fwd_a}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk($sformatf("xs_fwd_a%0d", i + 1), {30'd0, fwd_a}, 32'd1);
            chk($sformatf("xs_stall_cnt%0d", i + 1), {16'd0, stall_cnt}, 32'd1);
        end
        ext_stall = 1'b0;
        settle();
        chk_ctrl("xs_release", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        chk("xs_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        chk("xs_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk_ctrl("xs_resolved", 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // reset mid-stream drops a live forwarding path and clears counters
        id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        id_in(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        settle();
        chk("mid_pre_fwd_a", {30'd0, fwd_a}, 32'd1);
        rst = 1'b1;
        nop_in();
        settle();
        chk("mid_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk_ctrl("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        settle();
        chk("mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("mid_fwd_a", {30'd0, fwd_a}, 32'd0);
        id_in(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        nop_in();
        settle();
        chk("mid_no_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("mid_no_fwd_b", {30'd0, fwd_b}, 32'd0);

        // flush counter saturation
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        ex_branch_taken = 1'b0;
        settle();
        chk("sat_flush_cnt", {16'd0, flush_cnt}, 32'h0000ffff);
        chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
